// File: rtl/rpn_pkg.sv
// Shared opcode, status and state definitions for the RPN calculator controller.
package rpn_pkg;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_DUP  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;
  localparam logic [1:0] ERR_ARITH = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_EXEC,
    ST_WB
  } state_t;

  // Stack-bounds check for a command against the current depth d.
  function automatic logic [1:0] check_cmd(input logic [2:0] op,
                                           input int unsigned d,
                                           input int unsigned max_d);
    logic [1:0] e;
    e = ERR_OK;
    case (op)
      OP_PUSH:                        if (d == max_d) e = ERR_OVER;
      OP_POP:                         if (d == 0) e = ERR_UNDER;
      OP_ADD, OP_SUB, OP_MUL, OP_SWAP: if (d < 2) e = ERR_UNDER;
      OP_DUP: begin
        if (d == 0)          e = ERR_UNDER;
        else if (d == max_d) e = ERR_OVER;
      end
      default: e = ERR_OK;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN controller: a op b with wrap-around result
// and an unsigned-overflow flag.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    prod   = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        ovf    = sum[WIDTH];
      end
      OP_SUB: begin
        result = a - b;
        ovf    = (a < b);
      end
      OP_MUL: begin
        result = prod[WIDTH-1:0];
        ovf    = |prod[2*WIDTH-1:WIDTH];
      end
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rpn_ctrl.sv
// RPN calculator sequencing controller: owns the operand stack and steps each
// command through CHECK / EXEC / WB before returning to IDLE.
module rpn_ctrl
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             done,
  output logic [1:0]       err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       chk_q, chk_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             aovf_q, aovf_d;
  logic [1:0]       err_q, err_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  logic [AW-1:0]    i_top, i_sub, i_new;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             arith_op;

  assign i_top    = AW'(depth_q - DW'(1));
  assign i_sub    = AW'(depth_q - DW'(2));
  assign i_new    = AW'(depth_q);
  assign arith_op = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL);

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (stack_q[i_sub]),
    .b      (stack_q[i_top]),
    .op     (op_q),
    .result (alu_res),
    .ovf    (alu_ovf)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    chk_d     = chk_q;
    res_d     = res_q;
    aovf_d    = aovf_q;
    err_d     = err_q;
    depth_d   = depth_q;
    stack_d   = stack_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid && !reset) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        chk_d   = check_cmd(op_q, 32'(depth_q), DEPTH);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        res_d   = alu_res;
        aovf_d  = alu_ovf;
        state_d = ST_WB;
      end
      ST_WB: begin
        done    = 1'b1;
        state_d = ST_IDLE;
        if (chk_q != ERR_OK) begin
          err_d = chk_q;
        end else begin
          err_d = (arith_op && aovf_q) ? ERR_ARITH : ERR_OK;
          case (op_q)
            OP_PUSH: begin
              stack_d[i_new] = data_q;
              depth_d        = depth_q + DW'(1);
            end
            OP_POP: depth_d = depth_q - DW'(1);
            OP_ADD, OP_SUB, OP_MUL: begin
              stack_d[i_sub] = res_q;
              depth_d        = depth_q - DW'(1);
            end
            OP_DUP: begin
              stack_d[i_new] = stack_q[i_top];
              depth_d        = depth_q + DW'(1);
            end
            OP_SWAP: begin
              stack_d[i_top] = stack_q[i_sub];
              stack_d[i_sub] = stack_q[i_top];
            end
            default: depth_d = '0;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      chk_q   <= ERR_OK;
      res_q   <= '0;
      aovf_q  <= 1'b0;
      err_q   <= ERR_OK;
      depth_q <= '0;
      stack_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      chk_q   <= chk_d;
      res_q   <= res_d;
      aovf_q  <= aovf_d;
      err_q   <= err_d;
      depth_q <= depth_d;
      stack_q <= stack_d;
    end
  end

  assign top   = (depth_q == '0) ? '0 : stack_q[i_top];
  assign depth = depth_q;
  assign err   = err_q;

endmodule

// File: tb/tb_rpn_ctrl.sv
// Self-checking bench for rpn_ctrl: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_rpn_ctrl;

  localparam int W = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] top;
  logic [2:0] depth;
  logic       done;
  logic [1:0] err;

  rpn_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .top       (top),
    .depth     (depth),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model: committed stack as a queue, plus cycles since acceptance.
  logic [7:0] mq[$];
  int         m_phase = 0;
  logic [2:0] m_op;
  logic [7:0] m_data;
  int         m_err = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_apply();
    int d, a, b, r, e;
    d = mq.size();
    e = 0;
    case (m_op)
      3'd0: if (d == D) e = 2; else mq.push_back(m_data);
      3'd1: if (d == 0) e = 1; else void'(mq.pop_back());
      3'd2, 3'd3, 3'd4: begin
        if (d < 2) e = 1;
        else begin
          b = int'(mq.pop_back());
          a = int'(mq.pop_back());
          if (m_op == 3'd2) r = a + b;
          else if (m_op == 3'd3) r = a - b;
          else r = a * b;
          e = (r > 255 || r < 0) ? 3 : 0;
          mq.push_back(8'(r & 255));
        end
      end
      3'd5: if (d == 0) e = 1; else if (d == D) e = 2; else mq.push_back(mq[d-1]);
      3'd6: begin
        if (d < 2) e = 1;
        else begin
          logic [7:0] t;
          t = mq[d-1];
          mq[d-1] = mq[d-2];
          mq[d-2] = t;
        end
      end
      default: mq.delete();
    endcase
    m_err = e;
  endtask

  // Mirrors what one rising edge does, given the inputs held before it.
  task automatic model_step();
    if (reset) begin
      mq.delete();
      m_err   = 0;
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (cmd_valid) begin
        m_op    = cmd_op;
        m_data  = cmd_data;
        m_phase = 1;
      end
    end else if (m_phase == 3) begin
      model_apply();
      m_phase = 0;
    end else begin
      m_phase++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready", int'(cmd_ready), (m_phase == 0 && !reset) ? 1 : 0);
      check("done", int'(done), (m_phase == 3) ? 1 : 0);
      check("depth", int'(depth), mq.size());
      check("top", int'(top), (mq.size() == 0) ? 0 : int'(mq[mq.size()-1]));
      check("err", int'(err), m_err);
    end
  end

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] data);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    n = 0;
    while (m_phase == 0 && n < 8) begin
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    if (m_phase == 0) begin
      check("accept_timeout", 0, 1);
    end else begin
      repeat (3) tick();
    end
  endtask

  task automatic lit(input string name, input int t, input int d, input int e);
    check({name, "_top"}, int'(top), t);
    check({name, "_depth"}, int'(depth), d);
    check({name, "_err"}, int'(err), e);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    lit("reset", 0, 0, 0);

    do_cmd(3'd0, 8'h29);  lit("push29", 'h29, 1, 0);

    do_cmd(3'd7, 8'h00);
    do_cmd(3'd0, 8'h05);
    do_cmd(3'd0, 8'h03);
    do_cmd(3'd3, 8'h00);  lit("sub", 'h02, 1, 0);
    do_cmd(3'd0, 8'h04);
    do_cmd(3'd6, 8'h00);  lit("swap", 'h02, 2, 0);

    do_cmd(3'd7, 8'h00);
    do_cmd(3'd1, 8'h00);  lit("pop_empty", 0, 0, 1);
    do_cmd(3'd0, 8'h11);
    do_cmd(3'd2, 8'h00);  lit("add_under", 'h11, 1, 1);

    do_cmd(3'd7, 8'h00);
    for (int i = 1; i <= 4; i++) do_cmd(3'd0, 8'(i));
    do_cmd(3'd0, 8'h77);  lit("push_over", 4, 4, 2);
    do_cmd(3'd5, 8'h00);  lit("dup_over", 4, 4, 2);

    do_cmd(3'd7, 8'h00);
    do_cmd(3'd0, 8'hF0);
    do_cmd(3'd0, 8'h20);
    do_cmd(3'd2, 8'h00);  lit("add_ovf", 'h10, 1, 3);
    do_cmd(3'd0, 8'h10);
    do_cmd(3'd4, 8'h00);  lit("mul_ovf", 'h00, 1, 3);
    do_cmd(3'd0, 8'h02);
    do_cmd(3'd0, 8'h03);
    do_cmd(3'd4, 8'h00);  lit("mul_ok", 'h06, 2, 0);

    // Reset lands while the ADD is in EXEC: the command must vanish.
    do_cmd(3'd7, 8'h00);
    for (int i = 0; i < 3; i++) do_cmd(3'd0, 8'(8'h40 + i));
    cmd_valid = 1'b1;
    cmd_op    = 3'd2;
    tick();
    cmd_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    lit("abort", 0, 0, 0);
    check("abort_ready", int'(cmd_ready), 1);
    do_cmd(3'd7, 8'h00);  lit("clr_empty", 0, 0, 0);

    // Random traffic, including cmd_valid held across completion.
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 4) cmd_op = 3'd0;
      else cmd_op = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 1) == 1) cmd_data = 8'($urandom_range(0, 255));
      else cmd_data = 8'($urandom_range(0, 15));
      reset = ($urandom_range(0, 59) == 0);
      tick();
    end
    reset     = 1'b0;
    cmd_valid = 1'b0;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rpn_ctrl.md
Name: rpn_ctrl

Overview:
- Sequencing controller for the RPN calculator datapath. It owns the operand stack and steps each command (push, pop, arithmetic, stack manipulation) through a fixed check / execute / write-back schedule.
- It sits between the front end (debounced KEY enter pulse plus the SW value, encoded as commands) and the display logic (top of stack, depth and error to LEDR/HEX).
- It reports underflow, overflow and arithmetic-overflow status per command.

Parameters:
- WIDTH, 8: operand and stack entry width in bits.
- DEPTH, 4: number of stack entries (at least 2).
- DW, $clog2(DEPTH+1): width of the depth output (derived; not to be overridden).

Ports:
- CLOCK_50  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  a command is presented.
- cmd_ready  output  1  controller can accept a command this cycle.
- cmd_op  input  3  opcode: PUSH=0, POP=1, ADD=2, SUB=3, MUL=4, DUP=5, SWAP=6, CLR=7.
- cmd_data  input  WIDTH  operand for PUSH; ignored otherwise.
- top  output  WIDTH  current top-of-stack value; 0 when the stack is empty.
- depth  output  DW  number of valid stack entries.
- done  output  1  one-cycle pulse when a command completes.
- err  output  2  status of the last completed command: 0 OK, 1 UNDERFLOW, 2 OVERFLOW, 3 ARITH_OVF.

Behaviour:
- Reset, sampled on the CLOCK_50 edge:
  - state IDLE, depth 0, top 0, done 0, err 0, all stack entries cleared.
  - cmd_ready is 0 while reset is high.
- Handshake:
  - cmd_ready = (state==IDLE) && !reset.
  - A command is accepted on the edge where cmd_valid && cmd_ready; cmd_op and cmd_data are latched on that edge.
  - Inputs are ignored in all other states; there is no queueing.
- FSM: IDLE -> CHECK -> EXEC -> WB -> IDLE, one cycle per state, for every opcode including error cases.
  - A command accepted at edge n sees done=1 during cycle n+3 (WB).
  - cmd_ready returns to 1 in cycle n+4, giving a throughput of one command per 4 cycles.
- CHECK stage (let d = depth):
  - PUSH: OVERFLOW if d==DEPTH.
  - POP: UNDERFLOW if d==0.
  - ADD, SUB, MUL, SWAP: UNDERFLOW if d<2.
  - DUP: UNDERFLOW if d==0, else OVERFLOW if d==DEPTH.
  - CLR: never fails.
  - The error code is latched; an erroring command makes no stack or depth change in WB.
- EXEC stage: registered ALU result from b = stack[d-1] (top) and a = stack[d-2].
  - ADD: a+b.
  - SUB: a-b.
  - MUL: low WIDTH bits of a*b.
  - All results wrap modulo 2^WIDTH.
  - ARITH_OVF is flagged on: ADD carry out, SUB borrow (a<b), or MUL high half nonzero.
  - ARITH_OVF is informational only: the wrapped result is still written back.
- WB stage:
  - PUSH: stack[d]=cmd_data; d+1.
  - POP: d-1.
  - ADD, SUB, MUL: stack[d-2]=result; d-1.
  - DUP: stack[d]=stack[d-1]; d+1.
  - SWAP: exchange the top two entries.
  - CLR: d=0.
  - err is updated and done pulses in this same cycle.
- err holds its value until the next WB. top and depth change only on the WB edge.
- Entries above depth are don't-care internally, but top must read 0 when depth==0.
- Reset asserted in any state (mid-command) aborts the command: no WB, no done, stack emptied, IDLE on the following cycle.
- cmd_valid held high across completion is treated as a new command, accepted again at cycle n+4.

Decomposition:
- Package rpn_pkg: opcode localparams (OP_PUSH..OP_CLR), error code localparams (ERR_OK, ERR_UNDER, ERR_OVER, ERR_ARITH) and FSM state encodings.
- Sub-module rpn_alu: combinational, WIDTH-parameterised.
  - Inputs: a, b, op. Outputs: result, ovf.
  - rpn_ctrl registers its outputs in EXEC.
- Stack storage, pointer and FSM stay in rpn_ctrl.

Test Plan:
- Reset, then PUSH 0x29 -> cmd_ready=0 during cycles n+1..n+3; done at n+3; top=0x29, depth=1, err=0; cmd_ready=1 at n+4.
- PUSH 0x05, PUSH 0x03, SUB -> top=0x02, depth=1, err=0. Then PUSH 0x04, SWAP -> top=0x02, depth=2.
- From empty: POP -> err=1, depth=0, top=0. Then ADD with depth=1 -> err=1, stack unchanged.
- PUSH 4 values (DEPTH=4), then PUSH 0x77 -> err=2, depth=4, top unchanged. Then DUP -> err=2.
- PUSH 0xF0, PUSH 0x20, ADD -> top=0x10, err=3. Then PUSH 0x10, MUL -> top=0x00, err=3. Then PUSH 0x02, PUSH 0x03, MUL -> top=0x06, err=0.
- Push 3 values; accept ADD, assert reset in EXEC -> no done pulse, depth=0, top=0, cmd_ready=1 one cycle after reset deasserts. Then CLR on empty -> err=0, depth=0.
